trig_coax_tx: RTL and testbench

Digitizer-side trigger transmitter that drives per-channel trigger pulses onto the 16 coax lines feeding the trigger board. It turns rising edges of local trigger primitives into fixed-width pulses, then enforces a per-channel holdoff. It applies a global veto and channel mask, and can inject periodic test pulses. Per-channel sent and dropped counters are readable through a select mux for monitoring.

---
 rtl/trig_coax_tx.sv | 198 +++++++++++++++++++
 tb/tb_trig_coax_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_coax_tx.sv
`default_nettype none
// ============================================================================
// Module   : trig_coax_tx
// Brief    : Per-channel coax trigger pulser with holdoff, veto, channel mask,
//            periodic test pulses and saturating sent/dropped counters.
// Revision : 1.0 - initial release
// ============================================================================
module trig_coax_tx #(
  parameter int NCH  = 16,
  parameter int CNTW = 32
) (
  input  logic            clk_adc,
  input  logic            rst,
  input  logic [NCH-1:0]  trig_in,
  input  logic [7:0]      pulsewidth,
  input  logic [7:0]      holdoff,
  input  logic            veto,
  input  logic [NCH-1:0]  chan_mask,
  input  logic [CNTW-1:0] testpulse_period,
  input  logic [7:0]      cntsel,
  input  logic            resetcnt,
  output logic [NCH-1:0]  coax_out,
  output logic [NCH-1:0]  busy,
  output logic [CNTW-1:0] sentout,
  output logic [CNTW-1:0] dropout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic [7:0]      pw_q, pw_d, ho_q, ho_d, cntsel_q, cntsel_d;
  logic [NCH-1:0]  mask_q, mask_d, trig_q, trig_d, trig_prev_q, trig_prev_d;
  logic            veto_q, veto_d;
  logic [CNTW-1:0] period_q, period_d, auto_q, auto_d;
  logic [NCH-1:0]  coax_q, coax_d, busy_q, busy_d;
  logic [CNTW-1:0] sentout_q, sentout_d, dropout_q, dropout_d;

  logic            tp_fire;
  logic [NCH-1:0]  edge_w, req_w, fire_w, active_w;
  logic [CNTW-1:0] sent_arr [NCH];
  logic [CNTW-1:0] drop_arr [NCH];

  // Wrap on >= so a period shortened below the running count recovers at once
  assign tp_fire = (period_q != '0) && (auto_q >= period_q - CNTW'(1));
  assign edge_w  = trig_q & ~trig_prev_q;
  assign req_w   = mask_q & (edge_w | {NCH{tp_fire}});

  always_comb begin
    pw_d        = pulsewidth;
    ho_d        = holdoff;
    mask_d      = chan_mask;
    period_d    = testpulse_period;
    cntsel_d    = cntsel;
    trig_d      = trig_in;
    trig_prev_d = trig_q;
    veto_d      = veto;
    coax_d      = fire_w;
    busy_d      = active_w;
    if (period_q == '0 || tp_fire) begin
      auto_d = '0;
    end else begin
      auto_d = auto_q + CNTW'(1);
    end
    sentout_d = '0;
    dropout_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cntsel_q == 8'(c)) begin
        sentout_d = sent_arr[c];
        dropout_d = drop_arr[c];
      end
    end
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      pw_q        <= '0;
      ho_q        <= '0;
      mask_q      <= '0;
      period_q    <= '0;
      cntsel_q    <= '0;
      trig_q      <= '0;
      trig_prev_q <= '0;
      veto_q      <= 1'b0;
      auto_q      <= '0;
      coax_q      <= '0;
      busy_q      <= '0;
      sentout_q   <= '0;
      dropout_q   <= '0;
    end else begin
      pw_q        <= pw_d;
      ho_q        <= ho_d;
      mask_q      <= mask_d;
      period_q    <= period_d;
      cntsel_q    <= cntsel_d;
      trig_q      <= trig_d;
      trig_prev_q <= trig_prev_d;
      veto_q      <= veto_d;
      auto_q      <= auto_d;
      coax_q      <= coax_d;
      busy_q      <= busy_d;
      sentout_q   <= sentout_d;
      dropout_q   <= dropout_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d, hold_q, hold_d;
    logic [CNTW-1:0] sent_q, sent_d, drop_q, drop_d;
    logic            inc_sent, inc_drop;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      inc_sent = 1'b0;
      inc_drop = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_w[gi]) begin
            if (veto_q) begin
              inc_drop = 1'b1;
            end else begin
              inc_sent = 1'b1;
              state_d  = ST_FIRE;
              cnt_d    = (pw_q == 8'd0) ? 8'd1 : pw_q;
              hold_d   = ho_q;
            end
          end
        end
        ST_FIRE: begin
          inc_drop = req_w[gi];
          if (cnt_q <= 8'd1) begin
            if (hold_q == 8'd0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = hold_q;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_HOLD: begin
          inc_drop = req_w[gi];
          if (cnt_q <= 8'd1) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Clear wins over a same-cycle increment; counts stick at all-ones
      sent_d = sent_q;
      drop_d = drop_q;
      if (resetcnt) begin
        sent_d = '0;
        drop_d = '0;
      end else begin
        if (inc_sent && (sent_q != '1)) sent_d = sent_q + CNTW'(1);
        if (inc_drop && (drop_q != '1)) drop_d = drop_q + CNTW'(1);
      end
    end

    always_ff @(posedge clk_adc) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        hold_q  <= '0;
        sent_q  <= '0;
        drop_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        sent_q  <= sent_d;
        drop_q  <= drop_d;
      end
    end

    assign fire_w[gi]   = (state_q == ST_FIRE);
    assign active_w[gi] = (state_q != ST_IDLE);
    assign sent_arr[gi] = sent_q;
    assign drop_arr[gi] = drop_q;
  end

  assign coax_out = coax_q;
  assign busy     = busy_q;
  assign sentout  = sentout_q;
  assign dropout  = dropout_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_coax_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_coax_tx
// Brief    : Directed table-driven bench for trig_coax_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_coax_tx;

  localparam int NCH  = 16;
  localparam int CNTW = 32;

  logic            clk_adc = 1'b0;
  logic            rst;
  logic [NCH-1:0]  trig_in;
  logic [7:0]      pulsewidth;
  logic [7:0]      holdoff;
  logic            veto;
  logic [NCH-1:0]  chan_mask;
  logic [CNTW-1:0] testpulse_period;
  logic [7:0]      cntsel;
  logic            resetcnt;
  logic [NCH-1:0]  coax_out;
  logic [NCH-1:0]  busy;
  logic [CNTW-1:0] sentout;
  logic [CNTW-1:0] dropout;

  trig_coax_tx #(.NCH(NCH), .CNTW(CNTW)) dut (
    .clk_adc          (clk_adc),
    .rst              (rst),
    .trig_in          (trig_in),
    .pulsewidth       (pulsewidth),
    .holdoff          (holdoff),
    .veto             (veto),
    .chan_mask        (chan_mask),
    .testpulse_period (testpulse_period),
    .cntsel           (cntsel),
    .resetcnt         (resetcnt),
    .coax_out         (coax_out),
    .busy             (busy),
    .sentout          (sentout),
    .dropout          (dropout)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct {
    logic [NCH-1:0] trig;
    logic           veto;
    logic [NCH-1:0] exp_coax;
    logic [NCH-1:0] exp_busy;
  } vec_t;

  vec_t tbl [64];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] pw, input logic [7:0] ho,
                          input logic [15:0] m, input logic [31:0] per,
                          input logic [7:0] sel);
    pulsewidth       = pw;
    holdoff          = ho;
    chan_mask        = m;
    testpulse_period = per;
    cntsel           = sel;
    trig_in          = '0;
    veto             = 1'b0;
    resetcnt         = 1'b0;
    rst              = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic clear_tbl();
    for (int r = 0; r < 64; r++) begin
      tbl[r].trig     = '0;
      tbl[r].veto     = 1'b0;
      tbl[r].exp_coax = '0;
      tbl[r].exp_busy = '0;
    end
  endtask

  // Row r drives inputs ahead of edge r and checks outputs just after it
  task automatic run_tbl(input int n, input string nm);
    for (int r = 0; r < n; r++) begin
      trig_in = tbl[r].trig;
      veto    = tbl[r].veto;
      tick();
      check($sformatf("%s coax r%0d", nm, r), 32'(coax_out), 32'(tbl[r].exp_coax));
      check($sformatf("%s busy r%0d", nm, r), 32'(busy), 32'(tbl[r].exp_busy));
    end
    trig_in = '0;
    veto    = 1'b0;
  endtask

  task automatic read_cnt(input int ch, input logic [31:0] es, input logic [31:0] ed,
                          input string nm);
    cntsel = 8'(ch);
    tick();
    tick();
    check($sformatf("%s sent ch%0d", nm, ch), sentout, es);
    check($sformatf("%s dropped ch%0d", nm, ch), dropout, ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;

    // Reset state
    pulsewidth = 8'd4; holdoff = 8'd0; chan_mask = '1; testpulse_period = '0;
    cntsel = 8'd0; trig_in = '1; veto = 1'b0; resetcnt = 1'b0; rst = 1'b1;
    tick();
    tick();
    check("reset coax", 32'(coax_out), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset sentout", sentout, 32'h0);
    check("reset dropout", dropout, 32'h0);

    // Single edge on ch3, pw=4 holdoff=10
    do_reset(8'd4, 8'd10, 16'hFFFF, 32'd0, 8'd0);
    clear_tbl();
    for (int r = 0; r < 22; r++) begin
      tbl[r].trig[3]     = (r >= 2);
      tbl[r].exp_coax[3] = (r >= 4) && (r <= 7);
      tbl[r].exp_busy[3] = (r >= 4) && (r <= 17);
    end
    run_tbl(22, "single");
    read_cnt(3, 32'd1, 32'd0, "single");

    // Retrigger in holdoff (dropped), then at spacing 2+pw+ho (fires)
    do_reset(8'd2, 8'd5, 16'hFFFF, 32'd0, 8'd0);
    clear_tbl();
    for (int r = 0; r < 22; r++) begin
      tbl[r].trig[0]     = (r == 2) || (r == 6) || (r == 11);
      tbl[r].exp_coax[0] = (r == 4) || (r == 5) || (r == 13) || (r == 14);
      tbl[r].exp_busy[0] = ((r >= 4) && (r <= 10)) || ((r >= 13) && (r <= 19));
    end
    run_tbl(22, "retrig");
    read_cnt(0, 32'd2, 32'd1, "retrig");

    // pw=0, holdoff=0, trig toggling every 2 cycles on ch1
    do_reset(8'd0, 8'd0, 16'hFFFF, 32'd0, 8'd0);
    clear_tbl();
    for (int r = 0; r < 26; r++) begin
      tbl[r].trig[1]     = (r >= 2) && (((r - 2) % 4) < 2);
      tbl[r].exp_coax[1] = (r >= 4) && (((r - 4) % 4) == 0);
      tbl[r].exp_busy[1] = (r >= 4) && (((r - 4) % 4) == 0);
    end
    run_tbl(26, "pw0");
    read_cnt(1, 32'd6, 32'd0, "pw0");

    // Veto on ch5, channel 6 masked off
    do_reset(8'd3, 8'd2, 16'hFFBF, 32'd0, 8'd0);
    clear_tbl();
    for (int r = 0; r < 12; r++) begin
      tbl[r].veto    = (r >= 1) && (r <= 8);
      tbl[r].trig[5] = (r >= 3);
      tbl[r].trig[6] = (r >= 3);
    end
    run_tbl(12, "veto");
    read_cnt(5, 32'd0, 32'd1, "veto");
    read_cnt(6, 32'd0, 32'd0, "mask");

    // Periodic test pulses, period 100
    do_reset(8'd1, 8'd0, 16'hFFFF, 32'd100, 8'd0);
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (k == 100) check("tp coax before", 32'(coax_out), 32'h0);
      if (k == 101) check("tp coax pulse", 32'(coax_out), 32'h0000FFFF);
      if (k == 102) check("tp busy after", 32'(busy), 32'h0);
    end
    for (int ch = 0; ch < NCH; ch++) read_cnt(ch, 32'd10, 32'd0, "tp");
    testpulse_period = '0;
    hits = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k >= 2 && coax_out != '0) hits++;
    end
    check("tp stop pulses", 32'(hits), 32'd0);

    // Reset in the middle of a pulse
    do_reset(8'd8, 8'd0, 16'hFFFF, 32'd0, 8'd0);
    trig_in[4] = 1'b1;
    tick();
    tick();
    tick();
    check("midrst coax high", 32'(coax_out), 32'h00000010);
    rst = 1'b1;
    tick();
    check("midrst coax", 32'(coax_out), 32'h0);
    check("midrst busy", 32'(busy), 32'h0);
    rst = 1'b0;
    trig_in = '0;

    // Saturation from a preset near all-ones, then resetcnt with a firing edge
    do_reset(8'd1, 8'd0, 16'hFFFF, 32'd0, 8'd2);
    force dut.g_ch[2].sent_q = 32'hFFFFFFFE;
    tick();
    release dut.g_ch[2].sent_q;
    for (int f = 0; f < 3; f++) begin
      trig_in[2] = 1'b1;
      tick();
      trig_in[2] = 1'b0;
      tick();
      tick();
      tick();
    end
    read_cnt(2, 32'hFFFFFFFF, 32'd0, "sat");
    trig_in[2] = 1'b1;
    tick();
    resetcnt = 1'b1;
    tick();
    resetcnt = 1'b0;
    tick();
    check("rstcnt pulse", 32'(coax_out), 32'h00000004);
    trig_in = '0;
    read_cnt(2, 32'd0, 32'd0, "rstcnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
